seq_checker: RTL
================

Name: seq_checker

Overview:
- Sink-side counterpart to the lab2 pattern generator.
- Consumes an 8-bit sample stream and checks that each sample equals the previous sample plus STEP, modulo 256.
- Locks onto the stream, flags deviations, counts errors and declares loss of lock.
- Sits on the generator's out bus for self-checking simulation and board bring-up.

Parameters:
- WIDTH, 8, data width of the checked stream.
- STEP, 1, expected increment between consecutive samples, modulo 2^WIDTH.
- LOCK_CNT, 4, consecutive correct transitions required to lock (≥1).
- LOSS_CNT, 3, consecutive mismatches while locked that cause loss of lock (≥1).
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is a sample this cycle.
- in_data  in  WIDTH  sample from the generator.
- clear  in  1  synchronous, 1-cycle: zero err_count.
- locked  out  1  checker is in LOCKED state (registered).
- error  out  1  1-cycle pulse: mismatch detected while locked (registered).
- err_count  out  ERR_W  saturating count of mismatches while locked.

Behaviour:
- Reset, while rst=0, effective immediately (asynchronous):
  - outputs: locked=0, error=0, err_count=0.
  - internal: state=HUNT, have_prev=0, run=0, miss=0, prev/expected=0.
- Only cycles with in_valid=1 advance the checking logic. Idle cycles hold all state; error is 0 on idle cycles.
- All outputs are registered. The response to a sample taken at edge N is visible after edge N.
- Arithmetic: next = (prev + STEP) mod 2^WIDTH. The wrap from 255 to 0 is a correct transition when STEP=1.
- State HUNT:
  - First valid sample with have_prev=0: prev=in_data, have_prev=1, run=0.
  - Later samples: if in_data==next, run+1; otherwise run=0. In both cases prev=in_data.
  - When run reaches LOCK_CNT: go to LOCKED, locked=1, expected=in_data+STEP, miss=0.
  - No error pulses and no err_count changes in HUNT.
- State LOCKED:
  - Match (in_data==expected): miss=0.
  - Mismatch:
    - error pulses for one cycle.
    - err_count+1, saturating at 2^ERR_W-1.
    - miss+1.
  - In both cases expected advances by STEP (free-running reference), so a single glitch does not desync the checker.
  - When miss reaches LOSS_CNT: go to HUNT, locked=0, prev=in_data, have_prev=1, run=0. The error pulse for that sample still fires.
- clear:
  - Zeroes err_count.
  - Does not affect state, locked or error.
  - If clear and a mismatch occur in the same cycle: clear wins, so err_count=0, but error still pulses.
- Sustained rst=0 mid-stream discards lock state. Re-locking after release requires 1 + LOCK_CNT valid samples.

Test Plan:
- Lock: rst=0 then released; samples 10,11,12,13,14 with in_valid=1 each cycle → locked=1 after the edge sampling 14 (not earlier); error never asserted; err_count=0.
- Wrap and gaps: locked on 253; feed 254, idle 2 cycles, then 255, 0, 1 → locked stays 1; error stays 0.
- Single glitch: locked with expected=20; feed 99, then 21, 22 → exactly one error pulse (the cycle after 99); err_count=1; locked stays 1.
- Loss of lock and re-lock:
  - Locked with expected=40; feed 7, 7, 7 → three error pulses; err_count=3; locked=0 after the third.
  - Then feed 8, 9, 10, 11 → locked=1 after 11.
- Clear and saturation:
  - ERR_W=4: 20 mismatches while locked (LOSS_CNT raised to 32) → err_count holds 15.
  - Clear asserted in the same cycle as a mismatch → err_count=0 and error=1.
- Asynchronous reset: rst driven 0 between clock edges while locked with err_count=5 → locked=0 and err_count=0 before the next edge. After release, samples 3,4,5,6,7 re-lock.

Source files
------------

// File: rtl/seq_checker.sv
// Sink-side stream checker: locks onto a sequence that increments by STEP (mod 2^WIDTH),
// flags deviations while locked, counts them (saturating) and drops lock on sustained misses.
module seq_checker #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t             state, state_next;
    logic               have_prev, have_prev_next;
    logic [WIDTH-1:0]   prev, prev_next;
    logic [WIDTH-1:0]   expected, expected_next;
    logic [RUN_W-1:0]   run, run_next, run_inc;
    logic [MISS_W-1:0]  miss, miss_next, miss_inc;
    logic               error_next;
    logic [ERR_W-1:0]   err_count_next;

    assign run_inc  = run + RUN_W'(1);
    assign miss_inc = miss + MISS_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            have_prev <= 1'b0;
            prev      <= '0;
            expected  <= '0;
            run       <= '0;
            miss      <= '0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            have_prev <= have_prev_next;
            prev      <= prev_next;
            expected  <= expected_next;
            run       <= run_next;
            miss      <= miss_next;
            error     <= error_next;
            err_count <= err_count_next;
        end
    end

    // Only valid samples move the checker; idle cycles hold everything and keep error low.
    always_comb begin
        state_next     = state;
        have_prev_next = have_prev;
        prev_next      = prev;
        expected_next  = expected;
        run_next       = run;
        miss_next      = miss;
        error_next     = 1'b0;
        err_count_next = err_count;

        if (in_valid) begin
            case (state)
                HUNT: begin
                    prev_next = in_data;
                    if (!have_prev) begin
                        have_prev_next = 1'b1;
                        run_next       = '0;
                    end else if (in_data == prev + STEP_V) begin
                        if (run_inc == RUN_W'(LOCK_CNT)) begin
                            state_next    = LOCKED;
                            expected_next = in_data + STEP_V;
                            miss_next     = '0;
                            run_next      = '0;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                LOCKED: begin
                    // Reference free-runs so a single corrupted sample does not shift alignment.
                    expected_next = expected + STEP_V;
                    if (in_data == expected) begin
                        miss_next = '0;
                    end else begin
                        error_next = 1'b1;
                        if (err_count != '1) begin
                            err_count_next = err_count + ERR_W'(1);
                        end
                        if (miss_inc == MISS_W'(LOSS_CNT)) begin
                            state_next     = HUNT;
                            prev_next      = in_data;
                            have_prev_next = 1'b1;
                            run_next       = '0;
                            miss_next      = '0;
                        end else begin
                            miss_next = miss_inc;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (clear) begin
            err_count_next = '0;
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

endmodule
